mac_result_drain: RTL and testbench
===================================

// Module: mac_result_drain
// PURPOSE
//   Downstream consumer of one mac PE's result port (acc_out/valid_out). Keeps a shadow copy of
//   the PE's NUM_ACC accumulators. On a flush command it snapshots them and post-processes each
//   slot: arithmetic right shift, optional ReLU, saturation to OUT_W. Results stream out in slot
//   order over a valid/ready interface through a small FIFO, to the output writer.
// PARAMETERS
//   ACC_W      16  accumulator width; must equal the mac ACC_W
//   OUT_W      8   signed output word width (OUT_W <= ACC_W)
//   NUM_ACC    8   accumulator slots per PE; IDX_W = clog2(NUM_ACC)
//   FIFO_DEPTH 4   output FIFO entries, power of 2, >= 2
// PORTS
//   clk        in   1      clock, all state on posedge
//   rst        in   1      reset, synchronous, active-high
//   mac_valid  in   1      mac valid_out
//   mac_acc    in   ACC_W  mac acc_out, signed
//   mac_tag    in   IDX_W  slot of mac_acc; sequencer supplies acc_sel delayed 1 cycle
//   clear      in   1      same clear as the mac; zeroes the shadow file
//   flush      in   1      start a drain of all slots; sampled only in IDLE
//   shift      in   4      arithmetic right-shift amount, sampled with flush
//   relu_en    in   1      clamp negatives to 0, sampled with flush
//   out_valid  out  1      FIFO head valid
//   out_ready  in   1      consumer accepts head
//   out_data   out  OUT_W  processed result, signed
//   out_idx    out  IDX_W  slot index of out_data
//   out_last   out  1      high with slot NUM_ACC-1
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse: drain complete
// BEHAVIOUR
//   Reset: shadow and snapshot = 0, FIFO empty, state IDLE; out_valid, out_data, out_idx,
//     out_last, busy, done = 0. Reset mid-drain aborts: FIFO contents discarded, no done.
//   Shadow: clear -> all slots 0. Else mac_valid -> shadow[mac_tag] <= mac_acc.
//     Clear wins over a same-cycle mac_valid. Shadow updates continue in every state.
//   FSM IDLE -> DRAIN -> TAIL -> IDLE.
//     IDLE: flush -> snap <= next-cycle shadow value (includes same-cycle mac write or clear);
//       latch shift/relu_en; idx <= 0; go DRAIN.
//     DRAIN: push proc(snap[idx]) with tag idx and last=(idx==NUM_ACC-1) when push allowed;
//       idx++ per push. After pushing the last slot go TAIL.
//     TAIL: when the out_last word handshakes (out_valid & out_ready) go IDLE; done <= 1
//       for one cycle. busy is low in the done cycle. A flush in that cycle is accepted.
//     flush outside IDLE is ignored. shadow writes and clear never alter snap during a drain.
//   proc(x): v = x >>> shift (sign-extending); if relu_en and v<0 then v=0;
//     saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_data = v[OUT_W-1:0].
//   FIFO: out_data/out_idx/out_last are the head entry, registered; out_valid = !empty.
//     Pop on out_valid & out_ready. Push allowed when !full, or when full and popping that cycle.
//     Head is stable while out_valid & !out_ready. Words leave strictly in order 0..NUM_ACC-1.
//   Latency/throughput: flush in cycle 0 -> out_valid in cycle 2. With out_ready=1, one word per
//     cycle: idx 0..NUM_ACC-1 in cycles 2..NUM_ACC+1, done in cycle NUM_ACC+2.
// TESTING
//   T1 writes tag0..7 = 10,-20,300,-300,0,127,-128,5; flush, shift=0, relu=0, ready=1 ->
//      out 10,-20,127,-128,0,127,-128,5; idx 0..7; last only on idx7; done in cycle 10.
//   T2 slots 1000,-300,-300; shift=2, relu=1 -> 127,0,0; same with relu=0 -> 127,-75,-75.
//   T3 out_ready=0 for 12 cycles after flush -> FIFO holds 4 words, head stable,
//      busy=1; then ready=1 -> all 8 words in order, no loss or duplicates, done once.
//   T4 tag3 written 7 then 9 -> drains 9. A write of tag3=50 in cycle 1 of the drain
//      still drains 9; a second flush while busy is ignored (only 8 words).
//   T5 clear with mac_valid tag2=44 in the same cycle -> slot2 drains 0. Clear during DRAIN
//      does not alter the outputs of that drain.
//   T6 rst in cycle 4 of a drain -> next cycle out_valid=0, busy=0; no done.
//      A following flush drains the correct shadow values (both 0 after reset).

Source files
------------

// File: rtl/mac_result_drain_if.sv
// Result stream from mac_result_drain to the output writer.
// Ports (signals):
//   out_valid  FIFO head valid (driven by master)
//   out_ready  consumer accepts head (driven by slave)
//   out_data   processed signed result word
//   out_idx    accumulator slot index of out_data
//   out_last   high with the final slot of a drain
interface mac_result_drain_if #(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IDX_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mac_result_drain.sv
// Drains one mac PE's accumulators. A shadow register file tracks every mac result write; a flush
// snapshots it and streams each slot, shifted / ReLU'd / saturated, through a small output FIFO.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mac_valid    mac result valid; writes mac_acc into shadow[mac_tag]
//   mac_acc      signed accumulator value
//   mac_tag      slot index of mac_acc
//   clear        zeroes the shadow file (wins over mac_valid)
//   flush        start a drain of all slots (accepted only when idle)
//   shift        arithmetic right-shift amount, captured with flush
//   relu_en      clamp negatives to zero, captured with flush
//   out_if       result stream (valid/ready, data, idx, last)
//   busy         drain in progress
//   done         one-cycle pulse when the last word has been accepted
module mac_result_drain #(
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned NUM_ACC    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_ACC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mac_valid,
    input  logic signed [ACC_W-1:0] mac_acc,
    input  logic [IDX_W-1:0]        mac_tag,
    input  logic                    clear,
    input  logic                    flush,
    input  logic [3:0]              shift,
    input  logic                    relu_en,
    mac_result_drain_if.master      out_if,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned EntW = OUT_W + IDX_W + 1;
    localparam logic signed [ACC_W-1:0] SatMin = {ACC_W{1'b1}} << (OUT_W - 1);
    localparam logic signed [ACC_W-1:0] SatMax = ~SatMin;

    typedef enum logic [1:0] {StIdle, StDrain, StTail} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   shadow_q [NUM_ACC];
    logic [ACC_W-1:0]   shadow_d [NUM_ACC];
    logic [ACC_W-1:0]   snap_q   [NUM_ACC];
    logic [ACC_W-1:0]   snap_d   [NUM_ACC];
    logic [3:0]         shift_q, shift_d;
    logic               relu_q, relu_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic [EntW-1:0]    fifo_q [FIFO_DEPTH];
    logic [EntW-1:0]    fifo_d [FIFO_DEPTH];
    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PtrW:0]      wr_q, wr_d, rd_q, rd_d;

    logic               empty, full, pop, push, last_slot;
    logic [EntW-1:0]    head;
    logic signed [ACC_W-1:0] shifted, clamped;
    logic [OUT_W-1:0]   proc_data;

    // Shadow file follows the mac in every state.
    always_comb begin
        shadow_d = shadow_q;
        if (clear) begin
            for (int i = 0; i < NUM_ACC; i++) shadow_d[i] = '0;
        end else if (mac_valid) begin
            shadow_d[mac_tag] = mac_acc;
        end
    end

    // Post-processing of the current snapshot slot.
    always_comb begin
        shifted = $signed(snap_q[idx_q]) >>> shift_q;
        if (relu_q && shifted[ACC_W-1]) shifted = '0;
        if (shifted > SatMax)      clamped = SatMax;
        else if (shifted < SatMin) clamped = SatMin;
        else                       clamped = shifted;
        proc_data = clamped[OUT_W-1:0];
    end

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign pop       = !empty && out_if.out_ready;
    // A full FIFO still takes a word in the cycle its head leaves.
    assign push      = (state_q == StDrain) && (!full || pop);
    assign last_slot = (idx_q == IDX_W'(NUM_ACC - 1));
    assign head      = fifo_q[rd_q[PtrW-1:0]];

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
            fifo_d[wr_q[PtrW-1:0]] = {last_slot, idx_q, proc_data};
            wr_d = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    // Snapshot includes any write or clear landing this same cycle.
                    snap_d  = shadow_d;
                    shift_d = shift;
                    relu_d  = relu_en;
                    idx_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (push) begin
                    idx_d = idx_q + 1'b1;
                    if (last_slot) state_d = StTail;
                end
            end
            StTail: begin
                if (pop && head[EntW-1]) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            relu_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            relu_q   <= relu_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            fifo_q   <= fifo_d;
        end
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = head[OUT_W-1:0];
    assign out_if.out_idx   = head[OUT_W +: IDX_W];
    assign out_if.out_last  = head[EntW-1];
    assign busy             = (state_q != StIdle);
    assign done             = done_q;
endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;
    logic               clk = 1'b0;
    logic               rst;
    logic               mac_valid;
    logic signed [15:0] mac_acc;
    logic [2:0]         mac_tag;
    logic               clear;
    logic               flush;
    logic [3:0]         shift;
    logic               relu_en;
    logic               busy;
    logic               done;

    int vecs  = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];   // {last, idx, data}

    mac_result_drain_if #(.OUT_W(8), .IDX_W(3)) out_if ();

    mac_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .mac_valid (mac_valid),
        .mac_acc   (mac_acc),
        .mac_tag   (mac_tag),
        .clear     (clear),
        .flush     (flush),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_if    (out_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted word is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_if.out_valid && out_if.out_ready) begin
            logic [11:0] got, e;
            got = {out_if.out_last, out_if.out_idx, out_if.out_data};
            vecs++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got last=%0b idx=%0d data=%0d, none expected",
                         got[11], got[10:8], $signed(got[7:0]));
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL word: got last=%0b idx=%0d data=%0d, want last=%0b idx=%0d data=%0d",
                             got[11], got[10:8], $signed(got[7:0]),
                             e[11], e[10:8], $signed(e[7:0]));
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        vecs++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push8(input int v[8]);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, 3'(i), 8'(v[i])});
    endtask

    task automatic write_slot(input int tag, input int val);
        mac_valid = 1'b1;
        mac_tag   = 3'(tag);
        mac_acc   = 16'(val);
        cyc();
        mac_valid = 1'b0;
    endtask

    // Flush is high in "cycle 0"; returns at the start of cycle 1.
    task automatic start_flush(input int sh, input bit relu);
        flush   = 1'b1;
        shift   = 4'(sh);
        relu_en = relu;
        cyc();
        flush = 1'b0;
    endtask

    // Returns the cycle (relative to the flush) in which done is seen, or -1.
    task automatic wait_done(input int start, output int c);
        c = start;
        while (done !== 1'b1 && c < 300) begin
            cyc();
            c++;
        end
        if (done !== 1'b1) c = -1;
    endtask

    initial begin
        int v[8];
        int c;
        int d0;

        rst = 1'b1; mac_valid = 1'b0; mac_acc = '0; mac_tag = '0; clear = 1'b0;
        flush = 1'b0; shift = '0; relu_en = 1'b0; out_if.out_ready = 1'b0;
        repeat (3) cyc();
        check("rst_out_valid", int'(out_if.out_valid), 0);
        check("rst_out_data",  int'(out_if.out_data), 0);
        check("rst_out_idx",   int'(out_if.out_idx), 0);
        check("rst_out_last",  int'(out_if.out_last), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_done",      int'(done), 0);
        rst = 1'b0;
        cyc();

        // T1: saturation at shift 0, full-rate drain timing
        out_if.out_ready = 1'b1;
        v = '{10, -20, 300, -300, 0, 127, -128, 5};
        for (int i = 0; i < 8; i++) write_slot(i, v[i]);
        v = '{10, -20, 127, -128, 0, 127, -128, 5};
        push8(v);
        start_flush(0, 1'b0);
        check("t1_busy", int'(busy), 1);
        wait_done(1, c);
        check("t1_done_cycle", c, 10);
        check("t1_busy_in_done", int'(busy), 0);
        check("t1_queue_empty", exp_q.size(), 0);
        cyc();

        // T2: shift by 2 with and without ReLU
        clear = 1'b1; cyc(); clear = 1'b0;
        write_slot(0, 1000); write_slot(1, -300); write_slot(2, -300);
        v = '{127, 0, 0, 0, 0, 0, 0, 0};
        push8(v);
        start_flush(2, 1'b1);
        wait_done(1, c);
        check("t2_relu_done_cycle", c, 10);
        cyc();
        v = '{127, -75, -75, 0, 0, 0, 0, 0};
        push8(v);
        start_flush(2, 1'b0);
        wait_done(1, c);
        check("t2_norelu_done_cycle", c, 10);
        cyc();

        // T3: backpressure fills the FIFO; head must hold
        out_if.out_ready = 1'b0;
        v = '{127, -128, -128, 0, 0, 0, 0, 0};
        push8(v);
        d0 = done_cnt;
        start_flush(0, 1'b0);
        cyc();
        check("t3_valid_c2", int'(out_if.out_valid), 1);
        check("t3_head_data_c2", int'($signed(out_if.out_data)), 127);
        repeat (10) cyc();
        check("t3_valid_c12", int'(out_if.out_valid), 1);
        check("t3_busy_c12", int'(busy), 1);
        check("t3_head_data_c12", int'($signed(out_if.out_data)), 127);
        check("t3_head_idx_c12", int'(out_if.out_idx), 0);
        out_if.out_ready = 1'b1;
        wait_done(12, c);
        check("t3_done_seen", int'(c > 0), 1);
        cyc(); cyc();
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // T4: latest write wins; writes and flushes during a drain are ignored by it
        write_slot(3, 7); write_slot(3, 9);
        v = '{127, -128, -128, 9, 0, 0, 0, 0};
        push8(v);
        d0 = done_cnt;
        start_flush(0, 1'b0);
        mac_valid = 1'b1; mac_tag = 3'd3; mac_acc = 16'sd50; flush = 1'b1;
        cyc();
        mac_valid = 1'b0; flush = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_done(4, c);
        check("t4_done_cycle", c, 10);
        repeat (5) cyc();
        check("t4_done_once", done_cnt - d0, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // T5: clear beats same-cycle write; clear mid-drain leaves the snapshot alone
        clear = 1'b1; mac_valid = 1'b1; mac_tag = 3'd2; mac_acc = 16'sd44;
        cyc();
        clear = 1'b0; mac_valid = 1'b0;
        write_slot(0, 3);
        v = '{3, 0, 0, 0, 0, 0, 0, 0};
        push8(v);
        start_flush(0, 1'b0);
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        wait_done(3, c);
        check("t5_done_cycle", c, 10);
        // Flush in the done cycle is accepted
        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        push8(v);
        start_flush(0, 1'b0);
        wait_done(1, c);
        check("t5_back_to_back_done_cycle", c, 10);
        cyc();
        check("t5_queue_empty", exp_q.size(), 0);

        // T6: reset in the middle of a drain
        write_slot(0, 20); write_slot(1, -5);
        exp_q.push_back({1'b0, 3'd0, 8'(20)});
        exp_q.push_back({1'b0, 3'd1, 8'(-5)});
        d0 = done_cnt;
        start_flush(0, 1'b0);
        cyc(); cyc(); cyc();
        rst = 1'b1; out_if.out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        check("t6_valid_after_rst", int'(out_if.out_valid), 0);
        check("t6_busy_after_rst", int'(busy), 0);
        repeat (12) cyc();
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_queue_empty", exp_q.size(), 0);
        out_if.out_ready = 1'b1;
        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        push8(v);
        start_flush(0, 1'b0);
        wait_done(1, c);
        check("t6_redrain_done_cycle", c, 10);
        cyc(); cyc();
        check("t6_final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
